// File: rtl/counter_sweep_ctrl_if.sv
// Bundle between the sweep controller and its up/down counter plus host control/status.
interface counter_sweep_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int SW_W  = 8
);
  logic             go;
  logic             stop;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] count;
  logic             en;
  logic             busy;
  logic             at_lo;
  logic             at_hi;
  logic [SW_W-1:0]  sweeps;
  logic             cfg_err;
  logic             track_err;

  modport master (
    output go, stop, lo, hi, count,
    input  en, busy, at_lo, at_hi, sweeps, cfg_err, track_err
  );

  modport slave (
    input  go, stop, lo, hi, count,
    output en, busy, at_lo, at_hi, sweeps, cfg_err, track_err
  );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Drives an up/down counter's en so count sweeps lo..hi as a triangle, and checks it tracks.
// Optional macro SWEEP_AUTOSTOP_EN: return to IDLE after N_SWEEPS turnarounds per run.
module counter_sweep_ctrl #(
  parameter int WIDTH    = 8,
  parameter int SW_W     = 8,
  parameter int N_SWEEPS = 4
) (
  input logic                 clk,
  input logic                 rst,
  counter_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t           state;
  logic             en;
  logic             busy;
  logic             pv;
  logic             cfg_err;
  logic             track_err;
  logic [SW_W-1:0]  sweeps;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] exp_cnt;

  function automatic logic [WIDTH-1:0] predict(input logic dir, input logic [WIDTH-1:0] cur);
    return dir ? cur + WIDTH'(1) : cur - WIDTH'(1);
  endfunction

  assign nxt = predict(en, bus.count);

`ifdef SWEEP_AUTOSTOP_EN
  localparam int RUN_W = (N_SWEEPS > 1) ? $clog2(N_SWEEPS) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(N_SWEEPS - 1);
  logic [RUN_W-1:0] run_cnt;
`else
  // N_SWEEPS has no effect without auto-stop; referenced here only to keep it legal.
  if (N_SWEEPS < 1) begin : g_n_sweeps_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      en        <= 1'b0;
      busy      <= 1'b0;
      pv        <= 1'b0;
      sweeps    <= '0;
      cfg_err   <= 1'b0;
      track_err <= 1'b0;
`ifdef SWEEP_AUTOSTOP_EN
      run_cnt   <= '0;
`endif
    end else begin
      cfg_err <= 1'b0;
      if (pv && (bus.count != exp_cnt)) track_err <= 1'b1;
      case (state)
        IDLE: begin
          en   <= 1'b0;
          busy <= 1'b0;
          pv   <= 1'b0;
          if (bus.go && !bus.stop) begin
            if (bus.lo < bus.hi) begin
              state <= UP;
              en    <= 1'b1;
              busy  <= 1'b1;
`ifdef SWEEP_AUTOSTOP_EN
              run_cnt <= '0;
`endif
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        UP: begin
          if (bus.stop) begin
            state <= IDLE;
            en    <= 1'b0;
            busy  <= 1'b0;
            pv    <= 1'b0;
          end else begin
            pv <= 1'b1;
            if (nxt >= bus.hi) begin
              state <= DOWN;
              en    <= 1'b0;
            end else begin
              en <= 1'b1;
            end
          end
        end
        DOWN: begin
          if (bus.stop) begin
            state <= IDLE;
            en    <= 1'b0;
            busy  <= 1'b0;
            pv    <= 1'b0;
          end else begin
            pv <= 1'b1;
            if (nxt <= bus.lo) begin
              sweeps <= sweeps + SW_W'(1);
`ifdef SWEEP_AUTOSTOP_EN
              if (run_cnt == RUN_LAST) begin
                state <= IDLE;
                en    <= 1'b0;
                busy  <= 1'b0;
                pv    <= 1'b0;
              end else begin
                run_cnt <= run_cnt + RUN_W'(1);
                state   <= UP;
                en      <= 1'b1;
              end
`else
              state <= UP;
              en    <= 1'b1;
`endif
            end else begin
              en <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          en    <= 1'b0;
          busy  <= 1'b0;
          pv    <= 1'b0;
        end
      endcase
    end
  end

  // Expected count is pure data; pv qualifies it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state != IDLE) exp_cnt <= nxt;
  end

  assign bus.en        = en;
  assign bus.busy      = busy;
  assign bus.sweeps    = sweeps;
  assign bus.cfg_err   = cfg_err;
  assign bus.track_err = track_err;
  assign bus.at_lo     = (bus.count == bus.lo);
  assign bus.at_hi     = (bus.count == bus.hi);
endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: a counter driven by en, compared against an ideal triangle-wave model.
module tb_counter_sweep_ctrl;
  localparam int W   = 8;
  localparam int SWW = 8;
  localparam int NSW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  counter_sweep_ctrl_if #(.WIDTH(W), .SW_W(SWW)) bus ();

  counter_sweep_ctrl #(.WIDTH(W), .SW_W(SWW), .N_SWEEPS(NSW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Counter under control: follows en while the controller is busy, can be preloaded or made to skip.
  logic [W-1:0] cnt = '0;
  logic [W-1:0] load_val = '0;
  logic         load_req = 1'b0;
  logic         skip = 1'b0;

  always @(posedge clk) begin
    if (load_req) cnt <= load_val;
    else if (bus.busy === 1'b1) cnt <= bus.en ? cnt + (skip ? W'(2) : W'(1)) : cnt - W'(1);
  end

  assign bus.count = cnt;

  int n_vec  = 0;
  int n_err  = 0;
  int sw_base = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Ideal triangle: value k cycles after entry at c, bouncing between l and h.
  function automatic int tri_at(input int l, input int h, input int c, input int k);
    int span;
    int p;
    span = h - l;
    p = (c - l + k) % (2 * span);
    return (p <= span) ? l + p : h - (p - span);
  endfunction

  // Start a sweep at count c, check ncyc cycles against the model, stopping on the last one.
  task automatic run(input int l, input int h, input int c, input int ncyc);
    int  k_run;
    int  w;
    int  wn;
    bit  done;
    done = 1'b0;
    k_run = 0;
    bus.lo = W'(l);
    bus.hi = W'(h);
    load_val = W'(c);
    load_req = 1'b1;
    bus.go = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    bus.go = 1'b0;
    for (int k = 0; k < ncyc && !done; k++) begin
      k_run = (c - l + k) / (2 * (h - l));
`ifdef SWEEP_AUTOSTOP_EN
      if (k_run >= NSW) begin
        check("auto_busy", 32'(bus.busy), 0);
        check("auto_en", 32'(bus.en), 0);
        check("auto_sweeps", 32'(bus.sweeps), (sw_base + NSW) % (1 << SWW));
        check("auto_count", 32'(bus.count), l);
        done = 1'b1;
      end
`endif
      if (!done) begin
        w  = tri_at(l, h, c, k);
        wn = tri_at(l, h, c, k + 1);
        check("count", 32'(bus.count), w);
        check("en", 32'(bus.en), 32'(wn > w));
        check("busy", 32'(bus.busy), 1);
        check("sweeps", 32'(bus.sweeps), (sw_base + k_run) % (1 << SWW));
        check("at_lo", 32'(bus.at_lo), 32'(w == l));
        check("at_hi", 32'(bus.at_hi), 32'(w == h));
        check("cfg_err_run", 32'(bus.cfg_err), 0);
        check("track_err_run", 32'(bus.track_err), 0);
        if (k == ncyc - 1) bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
      end
    end
    if (done) begin
      sw_base += NSW;
    end else begin
      sw_base += k_run;
      check("stop_busy", 32'(bus.busy), 0);
      check("stop_en", 32'(bus.en), 0);
      check("stop_track", 32'(bus.track_err), 0);
    end
  endtask

  initial begin
    int l;
    int h;
    int c;
    bus.go = 1'b0;
    bus.stop = 1'b0;
    bus.lo = '0;
    bus.hi = '0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_en", 32'(bus.en), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_sweeps", 32'(bus.sweeps), 0);
    check("rst_cfg_err", 32'(bus.cfg_err), 0);
    check("rst_track_err", 32'(bus.track_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic triangle 2..5 entered at 2, one full sweep and a bit
    run(2, 5, 2, 8);
    check("first_sweeps", 32'(bus.sweeps), 1);

    // Bad configuration: lo == hi
    bus.lo = 8'd7;
    bus.hi = 8'd7;
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    check("cfg_err_pulse", 32'(bus.cfg_err), 1);
    check("cfg_busy", 32'(bus.busy), 0);
    check("cfg_en", 32'(bus.en), 0);
    @(negedge clk);
    check("cfg_err_clear", 32'(bus.cfg_err), 0);
    check("cfg_busy2", 32'(bus.busy), 0);

    // go and stop together in IDLE
    bus.lo = 8'd2;
    bus.hi = 8'd5;
    bus.go = 1'b1;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    bus.stop = 1'b0;
    check("gostop_busy", 32'(bus.busy), 0);
    check("gostop_en", 32'(bus.en), 0);
    check("gostop_cfg", 32'(bus.cfg_err), 0);

    // Stop while heading up at count 4
    run(2, 5, 2, 3);

    // Full range, two complete sweeps without wrapping
    run(0, 255, 0, 1021);

    // Randomized bounds, entry points and run lengths
    for (int r = 0; r < 12; r++) begin
      l = int'($urandom_range(0, 200));
      h = l + int'($urandom_range(1, 50));
      c = l + int'($urandom_range(0, h - l - 1));
      run(l, h, c, int'($urandom_range(1, 120)));
    end

    // Counter skips a value: 3 -> 5
    bus.lo = 8'd2;
    bus.hi = 8'd5;
    load_val = 8'd2;
    load_req = 1'b1;
    bus.go = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    bus.go = 1'b0;
    check("skip_track0", 32'(bus.track_err), 0);
    @(negedge clk);
    check("skip_count3", 32'(bus.count), 3);
    skip = 1'b1;
    @(negedge clk);
    skip = 1'b0;
    check("skip_count5", 32'(bus.count), 5);
    check("skip_track_pre", 32'(bus.track_err), 0);
    @(negedge clk);
    check("skip_track_set", 32'(bus.track_err), 1);
    repeat (3) begin
      @(negedge clk);
      check("skip_track_hold", 32'(bus.track_err), 1);
    end
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("skip_track_idle", 32'(bus.track_err), 1);
    check("skip_busy_idle", 32'(bus.busy), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sw_base = 0;
    check("rst2_track", 32'(bus.track_err), 0);
    check("rst2_sweeps", 32'(bus.sweeps), 0);
    check("rst2_busy", 32'(bus.busy), 0);
    check("rst2_en", 32'(bus.en), 0);

`ifdef SWEEP_AUTOSTOP_EN
    // Two auto-stopped runs of NSW sweeps each
    run(2, 5, 2, 30);
    check("auto_first", 32'(bus.sweeps), 3);
    run(2, 5, 2, 30);
    check("auto_total", 32'(bus.sweeps), 6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
Initiator-side controller for the team's up/down counter: it drives that counter's `en` input so the counter's `count` sweeps as a triangle wave between programmable bounds `lo` and `hi`. The counter counts up when `en`=1 and down when `en`=0, every cycle. The block watches the counter's `count` output, predicts the next value, reports endpoint and sweep status, and flags any cycle where the counter does not track the commanded direction.

Parameters:
- WIDTH, 8: width of `count`, `lo` and `hi`.
- SW_W, 8: width of the sweep counter.
- N_SWEEPS, 4: sweep limit, used only when SWEEP_AUTOSTOP_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start sweeping (level-sampled in IDLE).
- stop  in  1  return to IDLE; takes priority over `go`.
- lo  in  WIDTH  lower turnaround bound (unsigned).
- hi  in  WIDTH  upper turnaround bound (unsigned).
- count  in  WIDTH  current counter output.
- en  out  1  registered direction command to the counter.
- busy  out  1  high in UP or DOWN.
- at_lo  out  1  combinational: `count` == `lo`.
- at_hi  out  1  combinational: `count` == `hi`.
- sweeps  out  SW_W  completed DOWN->UP turnarounds.
- cfg_err  out  1  one-cycle pulse: `go` seen with `lo` >= `hi`.
- track_err  out  1  sticky: `count` differed from the predicted value.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset: state IDLE; `en`=0, `busy`=0, `sweeps`=0, `cfg_err`=0, `track_err`=0; prediction-valid flag `pv`=0.
- Prediction: `nxt` = `en` ? `count`+1 : `count`-1, modulo 2^WIDTH.
- IDLE:
  - `en` <= 0.
  - `go`=1, `stop`=0, `lo`<`hi`: go to UP, `en` <= 1.
  - `go`=1 with `lo`>=`hi`: stay in IDLE, `cfg_err` pulses for 1 cycle.
- UP:
  - `stop`=1: go to IDLE, `en` <= 0, `pv` <= 0.
  - else if `nxt` >= `hi`: go to DOWN, `en` <= 0.
  - else `en` stays 1.
- DOWN:
  - `stop`=1: go to IDLE, `en` <= 0, `pv` <= 0.
  - else if `nxt` <= `lo`: go to UP, `en` <= 1, `sweeps` += 1 (wraps at 2^SW_W).
  - else `en` stays 0.
- Resulting sequence: with `lo`=2, `hi`=5, entered at `count`=2, `count` runs 2,3,4,5,4,3,2,3,... Endpoints are hit exactly once per pass, never overshot.
- Entry out of range:
  - `count` > `hi` on entry: the first UP cycle turns around immediately.
  - `count` < `lo` while in DOWN: the block turns to UP.
- Tracking check:
  - In UP/DOWN, `exp` <= `nxt` and `pv` <= 1 every cycle.
  - If `pv`=1 and `count` != `exp`, `track_err` <= 1.
  - `track_err` clears only on `rst`.
  - The first active cycle after IDLE is not checked.
- `lo`/`hi` are sampled live. Changing them mid-sweep takes effect at the next comparison and is not an error.
- Simultaneous `go`+`stop` in IDLE: stay in IDLE.
- `rst` mid-sweep: all outputs return to reset values on the next edge.

Optional Feature:
- Macro SWEEP_AUTOSTOP_EN.
  - Defined: when `sweeps` increments to N_SWEEPS since the last IDLE->UP entry, the block returns to IDLE with `en` <= 0 on that same edge. A per-run counter clears on entry.
  - Undefined: sweeps run until `stop`; N_SWEEPS is unused.

Test Plan:
- Reset, then `go`, `lo`=2, `hi`=5, `count` from a model counter starting at 2 -> `en` sequence 1,1,1,0,0,0,1,...; `count` peaks at 5, floors at 2; `sweeps`=1 after the first return to 2.
- `go` with `lo`=7, `hi`=7 -> stays IDLE, `cfg_err` high 1 cycle, `en`=0, `busy`=0.
- Mid-sweep `stop` at `count`=4 heading up -> next edge `busy`=0, `en`=0; `track_err` remains 0.
- Model counter forced to skip one value (`count` 3->5) -> `track_err`=1 on the following cycle and stays set until `rst`.
- `lo`=0, `hi`=255, WIDTH=8, run 2 full sweeps -> no wrap past 255 or 0; `sweeps`=2.
- SWEEP_AUTOSTOP_EN defined, N_SWEEPS=3 -> `busy` drops on the edge `sweeps` reaches 3; `go` again -> runs 3 more sweeps, `sweeps`=6.
